// File: rtl/seg_disp_sched.sv
// seg_disp_sched: scan/scroll/edit scheduler for an 8-digit common-anode 7-seg bank.
// Optional feature macro: SEG_BLINK_EN (blinks the edited digit while in EDIT).
// Scan divider and index free-run; seg/an are registered from the current index.
module seg_disp_sched #(
  parameter int SCAN_DIV    = 50000,
  parameter int SCROLL_DIV  = 16666666,
  parameter int SCROLL_LAPS = 2,
  parameter int BLINK_DIV   = 12500000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] disp_data,
  input  logic        scroll_req,
  input  logic        edit_en,
  input  logic [3:0]  edit_pos,
  input  logic [3:0]  edit_val,
  output logic [7:0]  seg,
  output logic [7:0]  an,
  output logic        scroll_busy,
  output logic        scroll_done
);

  localparam int SW = (SCAN_DIV   > 1) ? $clog2(SCAN_DIV)   : 1;
  localparam int TW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam int LW = $clog2(SCROLL_LAPS + 1);

  // Elaboration-time parameter sanity
  generate
    if (SCAN_DIV < 1 || SCROLL_DIV < 1 || SCROLL_LAPS < 1 || BLINK_DIV < 1) begin : g_bad_param
      $error("seg_disp_sched: all dividers and SCROLL_LAPS must be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {ST_STATIC, ST_EDIT, ST_SCROLL} state_t;

  state_t          state, nstate;
  logic [SW-1:0]   scan_cnt;
  logic [2:0]      scan_idx;
  logic            req_q;
  logic [TW-1:0]   step_cnt;
  logic [2:0]      offset;
  logic [LW-1:0]   lap_cnt;
  logic            req_rise, step_tick, run_end, blank;
  logic [2:0]      sel_idx;
  logic [3:0]      nib;
  logic            overlay;
  logic [7:0]      seg_nxt;

  assign req_rise  = scroll_req & ~req_q;
  assign step_tick = (step_cnt == TW'(SCROLL_DIV - 1));
  assign run_end   = (state == ST_SCROLL) && step_tick && (offset == 3'd7) &&
                     (lap_cnt == LW'(SCROLL_LAPS - 1));

  // Active-low digit decode, dp kept off; A..F blank
  function automatic logic [7:0] dec7(input logic [3:0] n);
    case (n)
      4'd0: dec7 = 8'hC0;
      4'd1: dec7 = 8'hF9;
      4'd2: dec7 = 8'hA4;
      4'd3: dec7 = 8'hB0;
      4'd4: dec7 = 8'h99;
      4'd5: dec7 = 8'h92;
      4'd6: dec7 = 8'h82;
      4'd7: dec7 = 8'hF8;
      4'd8: dec7 = 8'h80;
      4'd9: dec7 = 8'h90;
      default: dec7 = 8'hFF;
    endcase
  endfunction

  // Free-running scan divider and digit index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      scan_idx <= 3'd0;
    end else if (scan_cnt == SW'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
      scan_idx <= scan_idx + 3'd1;
    end else begin
      scan_cnt <= scan_cnt + SW'(1);
    end
  end

  // scroll_req edge detector
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) req_q <= 1'b0;
    else        req_q <= scroll_req;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_STATIC;
    else        state <= nstate;
  end

  // FSM next state: a scroll request beats edit mode; scroll ignores everything until done
  always_comb begin
    nstate = state;
    case (state)
      ST_STATIC: if (req_rise) nstate = ST_SCROLL;
                 else if (edit_en) nstate = ST_EDIT;
      ST_EDIT:   if (req_rise) nstate = ST_SCROLL;
                 else if (!edit_en) nstate = ST_STATIC;
      ST_SCROLL: if (run_end) nstate = edit_en ? ST_EDIT : ST_STATIC;
      default:   nstate = ST_STATIC;
    endcase
  end

  // FSM outputs
  always_comb begin
    scroll_busy = (state == ST_SCROLL);
    scroll_done = run_end;
  end

  // Scroll step divider, offset and lap count; held cleared outside SCROLL so entry starts at 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_cnt <= '0;
      offset   <= 3'd0;
      lap_cnt  <= '0;
    end else if (state != ST_SCROLL) begin
      step_cnt <= '0;
      offset   <= 3'd0;
      lap_cnt  <= '0;
    end else if (step_tick) begin
      step_cnt <= '0;
      offset   <= offset + 3'd1;
      if (offset == 3'd7) lap_cnt <= lap_cnt + LW'(1);
    end else begin
      step_cnt <= step_cnt + TW'(1);
    end
  end

`ifdef SEG_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  logic [BW-1:0] blink_cnt;
  logic          blink_ph;

  // Blink phase runs only in EDIT and restarts from 0 on every entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
    end else if (state != ST_EDIT) begin
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
    end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
      blink_cnt <= '0;
      blink_ph  <= ~blink_ph;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

  assign blank = blink_ph;
`else
  assign blank = 1'b0;
`endif

  // Pick the nibble for the digit being scanned: rotated in SCROLL, overlaid in EDIT
  always_comb begin
    sel_idx = scan_idx + ((state == ST_SCROLL) ? offset : 3'd0);
    nib     = disp_data[{sel_idx, 2'b00} +: 4];
    overlay = (state == ST_EDIT) && !edit_pos[3] && (edit_pos[2:0] == scan_idx);
    if (overlay) nib = edit_val;
    seg_nxt = (overlay && blank) ? 8'hFF : dec7(nib);
  end

  // Registered drivers for the display pins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg <= 8'hFF;
      an  <= 8'hFF;
    end else begin
      seg <= seg_nxt;
      an  <= ~(8'd1 << scan_idx);
    end
  end

endmodule
